avmm_read_master: RTL
=====================

AVMM_READ_MASTER -- requirements
Module: avmm_read_master

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 9, meaning the number of 64-bit words fetched per run (range 1..16).
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, meaning the word address of the first read.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum cycles to wait for readdatavalid after a request is accepted.
REQ-004 The block SHALL have one clock and one reset: the clock SHALL be named clk and the reset SHALL be named rst, and rst SHALL be asynchronous and active-high.
REQ-005 The ports SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  single-cycle run request
- busy  output  1  high in REQ, WAIT and DRAIN
- done  output  1  level, high in DONE
- error  output  1  level, high in ERR
- state_dbg  output  3  encoding: IDLE=0, REQ=1, WAIT=2, DRAIN=3, DONE=4, ERR=5
- avm_address  output  32  word address
- avm_read  output  1  read request
- avm_readdata  input  64  response data
- avm_readdatavalid  input  1  single-cycle response strobe
- avm_waitrequest  input  1  responder stall
- out_byte  output  8  streamed byte
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accept
- out_row  output  4  index of the word being streamed
- out_last  output  1  final byte of final word

Function
REQ-006 In IDLE, start SHALL latch word index 0 and move to REQ on the next edge.
REQ-007 In REQ, avm_read SHALL be 1 and avm_address SHALL be BASE_ADDR+idx, held stable until accepted.
REQ-008 A request SHALL be accepted on a rising edge where avm_read=1 and avm_waitrequest=0; on acceptance the block SHALL enter WAIT and drive avm_read=0 from the next cycle.
REQ-009 At most one read SHALL be outstanding at any time.
REQ-010 In WAIT, a cycle counter SHALL start at 0 and increment each cycle.
REQ-011 In WAIT, avm_readdatavalid=1 SHALL capture avm_readdata into a 64-bit buffer, clear the byte counter and enter DRAIN on the same edge.
REQ-012 If the WAIT counter reaches TIMEOUT-1 without avm_readdatavalid, the block SHALL enter ERR.
REQ-013 avm_readdatavalid outside WAIT SHALL be ignored, with no state or data change.
REQ-014 In DRAIN, out_valid SHALL be 1 and out_byte SHALL be buffer byte k, MSB-first: k=0 is [63:56] and k=7 is [7:0].
REQ-015 In DRAIN, out_row SHALL equal idx.
REQ-016 k SHALL advance only on an edge where out_valid=1 and out_ready=1.
REQ-017 out_byte, out_row and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 out_last SHALL be 1 only when k=7 and idx=NUM_WORDS-1.
REQ-019 When byte 7 is accepted with idx<NUM_WORDS-1, the block SHALL increment idx and return to REQ; with idx=NUM_WORDS-1 it SHALL enter DONE.
REQ-020 DONE and ERR SHALL be held until start, which SHALL restart a run from idx 0 (transition to REQ).
REQ-021 start while busy SHALL be ignored.
REQ-022 Minimum latency from start to the first out_valid SHALL be 3 cycles plus the responder delay.
REQ-023 idx SHALL be 4 bits and k SHALL be 3 bits; neither SHALL wrap within a run.
REQ-024 Outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to avm_read or out_valid.

Reset
REQ-025 Asserting rst SHALL force IDLE immediately, at any point including mid-read or mid-drain.
REQ-026 Reset values SHALL be: avm_read=0, avm_address=0, out_valid=0, out_byte=0, out_row=0, out_last=0, busy=0, done=0, error=0, state_dbg=0, and the buffer, idx, k and counter all cleared.
REQ-027 A response arriving after rst deasserts SHALL be discarded per REQ-013.

Verification
REQ-028 Scenario: nominal run. Responder with 10-cycle delay holding words 0x0102030405060708..0x8182838485868788 at addresses 0..8, out_ready=1, pulse start -> 72 bytes streamed: 01,02..08,11..18,...,81..88; out_last only on byte 0x88; DONE with state_dbg=4.
REQ-029 Scenario: output backpressure. Toggle out_ready 1/0 every cycle -> same 72-byte sequence with no loss or duplication; out_byte stable while stalled.
REQ-030 Scenario: request stall. Hold avm_waitrequest=1 for 5 cycles during REQ -> avm_read and avm_address held constant; exactly one acceptance per address 0..8.
REQ-031 Scenario: timeout. Responder never returns readdatavalid for address 3 -> error=1 and state_dbg=5 after TIMEOUT cycles in WAIT; bytes for rows 0..2 only; a subsequent start reruns from address 0.
REQ-032 Scenario: mid-operation reset. Assert rst during DRAIN of row 4 -> all outputs reach reset values immediately; a stray readdatavalid afterwards does not change state.
REQ-033 Scenario: start during a run. Pulse start while busy -> no restart; idx keeps advancing and the run completes normally.

Source files
------------

// File: rtl/avmm_read_master.sv
// rtl/avmm_read_master.sv - fetches NUM_WORDS 64-bit words over Avalon-MM and streams them MSB byte first
module avmm_read_master #(
    parameter int          NUM_WORDS = 9,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic [63:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_row,
    output logic        out_last
);

    localparam int             CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [3:0]     IDX_LAST  = 4'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [2:0]    k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   buf_q, buf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            k_q     <= 3'd0;
            cnt_q   <= '0;
            buf_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_REQ;
                    idx_d   = 4'd0;
                    k_d     = 3'd0;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A response on the final counted cycle still wins over the timeout.
                if (avm_readdatavalid) begin
                    buf_d   = avm_readdata;
                    k_d     = 3'd0;
                    state_d = S_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (k_q == 3'd7) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_REQ;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is a decode of registered state; no input reaches them combinationally.
    assign state_dbg   = state_q;
    assign busy        = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign avm_read    = (state_q == S_REQ);
    assign avm_address = (state_q == S_REQ) ? (BASE_ADDR + {28'd0, idx_q}) : 32'd0;
    assign out_valid   = (state_q == S_DRAIN);
    assign out_byte    = (state_q == S_DRAIN) ? buf_q[{~k_q, 3'b000} +: 8] : 8'd0;
    assign out_row     = idx_q;
    assign out_last    = (state_q == S_DRAIN) && (k_q == 3'd7) && (idx_q == IDX_LAST);

endmodule
